// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Write-side front end for the 32x32 register file. Merges the in-order ALU
//   writeback with a FIFO-buffered long-latency result stream onto the file's
//   single write port. Writes to register 0 are never issued. A starvation
//   counter forces the FIFO head through after STARVE_LIMIT consecutive lost
//   arbitrations.
//
// Optional feature macro: RF_PENDING_MASK_EN
//   When defined, adds lng_pending_mask (one bit per register, set while any
//   FIFO entry targets that register) for the decode-stage hazard unit.
//
// Ports
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   alu_valid/ready  ALU writeback handshake, alu_addr/alu_data payload
//   lng_valid/ready  long-latency result handshake, lng_addr/lng_data payload
//   write_enabled    register-file write strobe (registered)
//   write_addr       register-file write address (registered)
//   write_data       register-file write data (registered)
//   q_count          FIFO occupancy
//   lng_pending_mask pending-destination mask (RF_PENDING_MASK_EN only)
module rf_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_WIDTH-1:0]       alu_addr,
    input  logic [DATA_WIDTH-1:0]       alu_data,
    input  logic                        lng_valid,
    output logic                        lng_ready,
    input  logic [ADDR_WIDTH-1:0]       lng_addr,
    input  logic [DATA_WIDTH-1:0]       lng_data,
    output logic                        write_enabled,
    output logic [ADDR_WIDTH-1:0]       write_addr,
    output logic [DATA_WIDTH-1:0]       write_data,
`ifdef RF_PENDING_MASK_EN
    output logic [2**ADDR_WIDTH-1:0]    lng_pending_mask,
`endif
    output logic [$clog2(LQ_DEPTH):0]   q_count
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] q_addr [LQ_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [SW-1:0]         starve;

    logic q_nonempty;
    logic force_head;
    logic push;
    logic pop;
    logic alu_win;

    assign q_nonempty = (q_count != '0);
    assign force_head = q_nonempty && (starve == SW'(STARVE_LIMIT));
    assign alu_ready  = !force_head;
    assign lng_ready  = (q_count != CW'(LQ_DEPTH));

    // Zero-destination long results complete the handshake but never enter the queue.
    assign push = lng_valid && lng_ready && (lng_addr != '0);

    // The head drains whenever the ALU is not issuing a real write, or when forced.
    assign pop     = q_nonempty && (force_head || !alu_valid || (alu_addr == '0));
    assign alu_win = !force_head && alu_valid && (alu_addr != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            q_addr[wr_ptr] <= lng_addr;
            q_data[wr_ptr] <= lng_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Counts cycles the ALU beats a non-empty queue; any pop or empty queue restarts it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve <= '0;
        end else if (!q_nonempty || pop) begin
            starve <= '0;
        end else if (alu_win && (starve != SW'(STARVE_LIMIT))) begin
            starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_enabled <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
        end else if (pop) begin
            write_enabled <= 1'b1;
            write_addr    <= q_addr[rd_ptr];
            write_data    <= q_data[rd_ptr];
        end else if (alu_win) begin
            write_enabled <= 1'b1;
            write_addr    <= alu_addr;
            write_data    <= alu_data;
        end else begin
            write_enabled <= 1'b0;
        end
    end

`ifdef RF_PENDING_MASK_EN
    // Per-slot occupancy lets the mask be rebuilt from post-edge contents, so
    // duplicate destinations stay flagged until their last entry retires.
    logic [LQ_DEPTH-1:0]     slot_valid;
    logic [LQ_DEPTH-1:0]     slot_valid_next;
    logic [2**ADDR_WIDTH-1:0] mask_next;
    logic [ADDR_WIDTH-1:0]   slot_addr;

    always_comb begin
        slot_valid_next = slot_valid;
        if (pop)  slot_valid_next[rd_ptr] = 1'b0;
        if (push) slot_valid_next[wr_ptr] = 1'b1;
        mask_next = '0;
        slot_addr = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            slot_addr = (push && (wr_ptr == PW'(i))) ? lng_addr : q_addr[i];
            if (slot_valid_next[i]) mask_next[slot_addr] = 1'b1;
        end
        mask_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid       <= '0;
            lng_pending_mask <= '0;
        end else begin
            slot_valid       <= slot_valid_next;
            lng_pending_mask <= mask_next;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed testbench for rf_write_arbiter. Inputs are driven and outputs
//   sampled on the falling edge; expected values are hand-derived constants.
//   Define RF_PENDING_MASK_EN for both files to exercise the pending mask.
module tb_rf_write_arbiter;

    logic        clock;
    logic        reset_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_addr;
    logic [31:0] lng_data;
    logic        write_enabled;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [2:0]  q_count;
`ifdef RF_PENDING_MASK_EN
    logic [31:0] lng_pending_mask;
`endif

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .LQ_DEPTH(4), .STARVE_LIMIT(3)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_addr(lng_addr), .lng_data(lng_data),
        .write_enabled(write_enabled), .write_addr(write_addr), .write_data(write_data),
`ifdef RF_PENDING_MASK_EN
        .lng_pending_mask(lng_pending_mask),
`endif
        .q_count(q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic expect_write(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, " we"},   64'(write_enabled), 64'(1));
        check({tag, " addr"}, 64'(write_addr), 64'(a));
        check({tag, " data"}, 64'(write_data), 64'(d));
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lng_valid = 1'b0; lng_addr = '0; lng_data = '0;
        step(); step();
        reset_n = 1'b1;
        step();

        // Reset state
        check("rst we",        64'(write_enabled), 64'(0));
        check("rst addr",      64'(write_addr), 64'(0));
        check("rst data",      64'(write_data), 64'(0));
        check("rst q_count",   64'(q_count), 64'(0));
        check("rst alu_ready", 64'(alu_ready), 64'(1));
        check("rst lng_ready", 64'(lng_ready), 64'(1));

        // ALU only
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11111111;
        step();
        expect_write("alu", 5'd5, 32'h11111111);
        alu_valid = 1'b0;
        step();
        check("idle we",   64'(write_enabled), 64'(0));
        check("idle hold", 64'(write_addr), 64'(5));

        // Zero-register suppression
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEADBEEF;
        check("zero alu_ready", 64'(alu_ready), 64'(1));
        step();
        check("zero alu we",   64'(write_enabled), 64'(0));
        check("zero alu hold", 64'(write_data), 64'(32'h11111111));
        alu_valid = 1'b0;
        lng_valid = 1'b1; lng_addr = 5'd0; lng_data = 32'h12345678;
        check("zero lng_ready", 64'(lng_ready), 64'(1));
        step();
        lng_valid = 1'b0;
        check("zero lng q",  64'(q_count), 64'(0));
        step();
        check("zero lng we", 64'(write_enabled), 64'(0));

        // Full FIFO with ALU hogging the port
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA1A1A1A1;
        lng_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lng_addr = 5'(8 + i); lng_data = 32'(8 + i);
            step();
            check($sformatf("full q%0d", i + 1), 64'(q_count), 64'(i + 1));
        end
        check("full lng_ready", 64'(lng_ready), 64'(0));
        check("full alu_ready", 64'(alu_ready), 64'(0));
`ifdef RF_PENDING_MASK_EN
        check("full mask", 64'(lng_pending_mask), 64'(32'h00000F00));
`endif
        lng_addr = 5'd12; lng_data = 32'd12;
        step();
        check("full pop q", 64'(q_count), 64'(3));
        expect_write("full pop", 5'd8, 32'd8);
        check("full reopen", 64'(lng_ready), 64'(1));
        step();
        check("full push5 q", 64'(q_count), 64'(4));
        expect_write("full alu", 5'd1, 32'hA1A1A1A1);
        alu_valid = 1'b0; lng_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_write($sformatf("drain%0d", i), 5'(9 + i), 32'(9 + i));
        end
        step();
        check("drained we", 64'(write_enabled), 64'(0));
        check("drained q",  64'(q_count), 64'(0));

        // Starvation
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22222222;
        lng_valid = 1'b1; lng_addr = 5'd9; lng_data = 32'hCAFEF00D;
        step();
        lng_valid = 1'b0;
        check("starve q", 64'(q_count), 64'(1));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!alu_ready) break;
            n++;
            step();
            check($sformatf("starve alu%0d", n), 64'(write_addr), 64'(2));
        end
        check("starve alu wins", 64'(n), 64'(3));
        check("starve ready0", 64'(alu_ready), 64'(0));
        step();
        expect_write("starve force", 5'd9, 32'hCAFEF00D);
        check("starve ready1", 64'(alu_ready), 64'(1));
        check("starve q0", 64'(q_count), 64'(0));
        step();
        expect_write("starve resume", 5'd2, 32'h22222222);
        alu_valid = 1'b0;
        step();

        // Order and pointer wrap
        lng_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            lng_addr = 5'(i); lng_data = 32'(i);
            step();
            if (i > 1) expect_write($sformatf("order%0d", i - 1), 5'(i - 1), 32'(i - 1));
`ifdef RF_PENDING_MASK_EN
            check($sformatf("order mask%0d", i), 64'(lng_pending_mask), 64'(32'd1 << i));
`endif
        end
        lng_valid = 1'b0;
        step();
        expect_write("order10", 5'd10, 32'd10);
`ifdef RF_PENDING_MASK_EN
        check("order mask clr", 64'(lng_pending_mask), 64'(0));
`endif
        step();
        check("order idle", 64'(write_enabled), 64'(0));

        // Reset mid-stream
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33333333;
        lng_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lng_addr = 5'(20 + i); lng_data = 32'(20 + i);
            step();
        end
        alu_valid = 1'b0; lng_valid = 1'b0;
        check("mid q3", 64'(q_count), 64'(3));
        check("mid we", 64'(write_enabled), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("mid rst we",   64'(write_enabled), 64'(0));
        check("mid rst q",    64'(q_count), 64'(0));
        check("mid rst addr", 64'(write_addr), 64'(0));
`ifdef RF_PENDING_MASK_EN
        check("mid rst mask", 64'(lng_pending_mask), 64'(0));
`endif
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post rst we%0d", i), 64'(write_enabled), 64'(0));
            check($sformatf("post rst q%0d", i),  64'(q_count), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Write-side front end for the 32x32 register file.
- Merges two writeback sources into the file's single write port (write_enabled / write_addr / write_data):
  - the in-order ALU pipeline result;
  - a long-latency result stream (multiply/divide or load return), buffered in a small FIFO.
- Enforces MIPS $zero semantics: writes to register 0 are never issued.
- Prevents the long-latency path from being starved by a continuous ALU stream.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width
- LQ_DEPTH, 4, long-latency FIFO entries; power of two, at least 2
- STARVE_LIMIT, 3, consecutive lost arbitrations before the FIFO head is forced through

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_addr  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- lng_valid  input  1  long-latency result valid
- lng_ready  output  1  FIFO can accept
- lng_addr  input  ADDR_WIDTH  long-latency destination register
- lng_data  input  DATA_WIDTH  long-latency result
- write_enabled  output  1  register-file write strobe
- write_addr  output  ADDR_WIDTH  register-file write address
- write_data  output  DATA_WIDTH  register-file write data
- q_count  output  clog2(LQ_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - write_enabled=0, write_addr=0, write_data=0;
  - FIFO flushed, q_count=0, starve counter=0;
  - queued entries are lost.
- All write_* outputs are registered. A granted request appears on write_* on the clock edge that accepts it, so it is visible one cycle after presentation.
- lng_ready = (q_count != LQ_DEPTH). Combinational from registered state only; it does not depend on lng_valid.
- Push on lng_valid & lng_ready:
  - lng_addr != 0: entry enqueued.
  - lng_addr == 0: handshake completes, nothing enqueued.
- No bypass: a long result reaches write_* no earlier than 2 edges after acceptance.
- alu_ready = !force, where force = (q_count != 0) & (starve == STARVE_LIMIT).
- Arbitration, evaluated each cycle:
  1. force: pop the FIFO head and drive it. An ALU request is not taken; the ALU holds.
  2. Else if alu_valid & alu_addr != 0: drive the ALU write.
  3. Else if alu_valid & alu_addr == 0: ALU accepted (alu_ready=1), no write issued. If q_count != 0, pop the head in the same cycle.
  4. Else if q_count != 0: pop the head and drive it.
  5. Else: write_enabled=0 next cycle; write_addr/write_data hold their previous values.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) on each cycle where q_count != 0 and the ALU wins;
  - clears on any pop, and whenever q_count == 0.
- Push and pop in the same cycle are legal: q_count is unchanged. When full, lng_ready=0 even if a pop occurs that cycle.
- FIFO pointers wrap modulo LQ_DEPTH; entries pop in acceptance order.
- Ordering between the ALU and long-latency streams to the same register is upstream hazard logic's responsibility. The block does not reorder or merge.

Optional Feature:
- Macro: RF_PENDING_MASK_EN.
- Defined: adds output lng_pending_mask, width 2**ADDR_WIDTH, registered.
  - Bit r = 1 while any FIFO entry targets register r.
  - Updated on the same edge as push/pop.
  - Bit 0 is always 0.
  - Resets to 0.
  - Provided for the decode-stage hazard unit.
- Undefined: port absent; no mask logic.

Test Plan:
- Reset mid-stream: fill FIFO with 3 entries, assert reset_n=0 between edges -> write_enabled=0 and q_count=0 immediately; after release, no stale writes.
- ALU only: alu_valid=1, alu_addr=5, alu_data=32'h11111111 -> next cycle write_enabled=1, write_addr=5, write_data=32'h11111111.
- Zero suppression:
  - alu_addr=0, data 32'hDEADBEEF -> write_enabled stays 0, alu_ready=1;
  - lng_addr=0 accepted -> q_count unchanged.
- Full FIFO: push 4 long results (addr 8..11) with ALU idle-blocked, i.e. alu_valid continuously to addr 1 -> lng_ready=0 after the 4th push; 5th held until a pop.
- Starvation: alu_valid continuously to addr 2, one long result to addr 9 = 32'hCAFEF00D -> exactly 3 ALU writes, then alu_ready=0 for one cycle with write_addr=9, write_data=32'hCAFEF00D; then ALU resumes.
- Order/wrap: push 10 long results (addr 1..10, data=addr) with ALU idle -> writes appear addr 1..10 in order, one per cycle. With RF_PENDING_MASK_EN, the mask clears each bit as its entry retires.
